// File: rtl/memory_access_stage_pkg.sv
// Shared MIPS pipeline definitions used by the MEM stage.
// Holds the register bundles, the access-size encoding and the stage FSM states.
package memory_access_stage_pkg;

    typedef logic [4:0] MipsReg;

    typedef enum logic [1:0] {
        BYTE = 2'd0,
        HALF = 2'd1,
        WORD = 2'd2
    } MemSize;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } MemStageState;

    typedef struct packed {
        logic   mem_read;
        logic   mem_write;
        MemSize mem_size;
        logic   mem_unsigned;
        logic   reg_write;
        logic   is_syscall;
    } MemCtrl;

    typedef struct packed {
        logic        valid;
        MemCtrl      ctrl;
        logic [31:0] alu_result;
        logic [31:0] rs_data;
        logic [31:0] rt_data;
        MipsReg      reg_write_addr;
    } EX_MEM_Register;

    typedef struct packed {
        logic        valid;
        MemCtrl      ctrl;
        logic [31:0] reg_write_data;
        logic [31:0] rs_data;
        logic [31:0] rt_data;
        MipsReg      reg_write_addr;
    } MEM_WB_Register;

    // Any size other than byte/half is treated as a full word.
    function automatic logic is_aligned(input MemSize size, input logic [1:0] lane);
        logic ok;
        case (size)
            BYTE:    ok = 1'b1;
            HALF:    ok = ~lane[0];
            default: ok = (lane == 2'b00);
        endcase
        return ok;
    endfunction

endpackage

// File: rtl/memory_access_stage_mem_data_align.sv
// Combinational byte-lane steering for the MEM stage.
// Extracts/extends load data and builds store byte enables plus replicated write data.
module mem_data_align
    import memory_access_stage_pkg::*;
(
    input  MemSize      size,
    input  logic        is_unsigned,
    input  logic [1:0]  lane,
    input  logic [31:0] rdata,
    input  logic [31:0] store_data,
    output logic [31:0] load_data,
    output logic [3:0]  be,
    output logic [31:0] wdata
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    assign byte_sel = rdata[{lane, 3'b000} +: 8];
    assign half_sel = rdata[{lane[1], 4'b0000} +: 16];

    always_comb begin
        load_data = rdata;
        be        = 4'hF;
        wdata     = store_data;
        case (size)
            BYTE: begin
                load_data = is_unsigned ? {24'h0, byte_sel} : {{24{byte_sel[7]}}, byte_sel};
                be        = 4'b0001 << lane;
                wdata     = {4{store_data[7:0]}};
            end
            HALF: begin
                load_data = is_unsigned ? {16'h0, half_sel} : {{16{half_sel[15]}}, half_sel};
                be        = 4'b0011 << lane;
                wdata     = {2{store_data[15:0]}};
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/memory_access_stage.sv
// MEM pipeline stage: issues loads/stores on a request/ready bus, formats results,
// and registers them into MEM/WB while stalling upstream during outstanding accesses.
module memory_access_stage
    import memory_access_stage_pkg::*;
#(
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              stall,
    input  EX_MEM_Register    ex_mem_reg,
    output MEM_WB_Register    mem_wb_reg,
    output logic              mem_stall_req,
    output logic              addr_error,
    output logic              dmem_req,
    output logic              dmem_we,
    output logic [ADDR_W-1:0] dmem_addr,
    output logic [3:0]        dmem_be,
    output logic [31:0]       dmem_wdata,
    input  logic              dmem_ready,
    input  logic [31:0]       dmem_rdata
);

    MemStageState   state, state_next;
    EX_MEM_Register pend;
    MEM_WB_Register hold_reg;
    MEM_WB_Register pass_result;
    MEM_WB_Register mem_result;
    logic           pend_flushed;
    logic           mem_op;
    logic           aligned;
    logic           issue;
    logic           misaligned;
    MemSize         align_size;
    logic           align_unsigned;
    logic [1:0]     align_lane;
    logic [31:0]    align_rt;
    logic [31:0]    load_data;
    logic [31:0]    store_wdata;
    logic [3:0]     store_be;

    assign mem_op     = ex_mem_reg.valid & (ex_mem_reg.ctrl.mem_read | ex_mem_reg.ctrl.mem_write);
    assign aligned    = is_aligned(ex_mem_reg.ctrl.mem_size, ex_mem_reg.alu_result[1:0]);
    assign issue      = (state == IDLE) & mem_op & aligned & ~flush;
    assign misaligned = (state == IDLE) & mem_op & ~aligned & ~flush;

    // In IDLE the aligner formats the incoming store; afterwards it formats the pending load.
    assign align_size     = (state == IDLE) ? ex_mem_reg.ctrl.mem_size     : pend.ctrl.mem_size;
    assign align_unsigned = (state == IDLE) ? ex_mem_reg.ctrl.mem_unsigned : pend.ctrl.mem_unsigned;
    assign align_lane     = (state == IDLE) ? ex_mem_reg.alu_result[1:0]   : pend.alu_result[1:0];
    assign align_rt       = (state == IDLE) ? ex_mem_reg.rt_data           : pend.rt_data;

    mem_data_align u_align (
        .size        (align_size),
        .is_unsigned (align_unsigned),
        .lane        (align_lane),
        .rdata       (dmem_rdata),
        .store_data  (align_rt),
        .load_data   (load_data),
        .be          (store_be),
        .wdata       (store_wdata)
    );

    assign mem_stall_req = issue | ((state == ACCESS) & ~dmem_ready) | (state == DONE);

    always_comb begin
        pass_result                = '0;
        pass_result.valid          = 1'b1;
        pass_result.ctrl           = ex_mem_reg.ctrl;
        pass_result.reg_write_data = ex_mem_reg.alu_result;
        pass_result.rs_data        = ex_mem_reg.rs_data;
        pass_result.rt_data        = ex_mem_reg.rt_data;
        pass_result.reg_write_addr = ex_mem_reg.reg_write_addr;

        mem_result                 = '0;
        mem_result.valid           = pend.valid;
        mem_result.ctrl            = pend.ctrl;
        mem_result.reg_write_data  = pend.ctrl.mem_read ? load_data : pend.alu_result;
        mem_result.rs_data         = pend.rs_data;
        mem_result.rt_data         = pend.rt_data;
        mem_result.reg_write_addr  = pend.reg_write_addr;
    end

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    // A flushed access still has to wait for ready; only the result is dropped.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (issue) state_next = ACCESS;
            ACCESS:  if (dmem_ready) state_next = (stall && !pend_flushed && !flush) ? DONE : IDLE;
            DONE:    if (flush || !stall) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            dmem_req     <= 1'b0;
            dmem_we      <= 1'b0;
            dmem_addr    <= '0;
            dmem_be      <= 4'h0;
            dmem_wdata   <= 32'h0;
            mem_wb_reg   <= '0;
            hold_reg     <= '0;
            pend         <= '0;
            pend_flushed <= 1'b0;
            addr_error   <= 1'b0;
        end else begin
            addr_error <= misaligned;
            case (state)
                IDLE: begin
                    pend_flushed <= 1'b0;
                    if (issue) begin
                        pend       <= ex_mem_reg;
                        dmem_req   <= 1'b1;
                        dmem_we    <= ex_mem_reg.ctrl.mem_write;
                        dmem_addr  <= {ex_mem_reg.alu_result[ADDR_W-1:2], 2'b00};
                        dmem_be    <= ex_mem_reg.ctrl.mem_write ? store_be : 4'h0;
                        dmem_wdata <= store_wdata;
                        if (!stall) mem_wb_reg.valid <= 1'b0;
                    end else if (flush) begin
                        mem_wb_reg.valid <= 1'b0;
                    end else if (!stall) begin
                        if (ex_mem_reg.valid && !mem_op) mem_wb_reg <= pass_result;
                        else                             mem_wb_reg.valid <= 1'b0;
                    end
                end
                ACCESS: begin
                    if (flush) pend_flushed <= 1'b1;
                    if (dmem_ready) begin
                        dmem_req <= 1'b0;
                        if (pend_flushed || flush) begin
                            if (!stall) mem_wb_reg.valid <= 1'b0;
                        end else if (!stall) begin
                            mem_wb_reg <= mem_result;
                        end else begin
                            hold_reg <= mem_result;
                        end
                    end else if (!stall) begin
                        mem_wb_reg.valid <= 1'b0;
                    end
                end
                DONE: begin
                    if (!stall) begin
                        if (flush) mem_wb_reg.valid <= 1'b0;
                        else       mem_wb_reg <= hold_reg;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_memory_access_stage.sv
// Self-checking bench for memory_access_stage: directed scenarios plus randomized
// loads/stores/ALU ops checked against a byte-level reference model.
module tb_memory_access_stage;
    import memory_access_stage_pkg::*;

    logic           clk;
    logic           rst;
    logic           flush;
    logic           stall;
    EX_MEM_Register ex_mem_reg;
    MEM_WB_Register mem_wb_reg;
    logic           mem_stall_req;
    logic           addr_error;
    logic           dmem_req;
    logic           dmem_we;
    logic [31:0]    dmem_addr;
    logic [3:0]     dmem_be;
    logic [31:0]    dmem_wdata;
    logic           dmem_ready;
    logic [31:0]    dmem_rdata;

    int total = 0;
    int bad   = 0;

    memory_access_stage #(.ADDR_W(32)) dut (
        .clk           (clk),
        .rst           (rst),
        .flush         (flush),
        .stall         (stall),
        .ex_mem_reg    (ex_mem_reg),
        .mem_wb_reg    (mem_wb_reg),
        .mem_stall_req (mem_stall_req),
        .addr_error    (addr_error),
        .dmem_req      (dmem_req),
        .dmem_we       (dmem_we),
        .dmem_addr     (dmem_addr),
        .dmem_be       (dmem_be),
        .dmem_wdata    (dmem_wdata),
        .dmem_ready    (dmem_ready),
        .dmem_rdata    (dmem_rdata)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("[TB] FAIL %s got=0x%08h expected=0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic applyStimulus(input EX_MEM_Register op);
        ex_mem_reg = op;
        #1;
    endtask

    // Reference model: little-endian byte lanes, computed with plain arithmetic.
    function automatic logic [31:0] modelLoad(input logic [1:0] size, input logic uns,
                                              input logic [1:0] lane, input logic [31:0] word);
        logic [31:0] v;
        int          bits;
        if (size == 2'd0) begin
            v = (word >> (8 * int'(lane))) & 32'hFF;
            bits = 8;
        end else if (size == 2'd1) begin
            v = (word >> (16 * (int'(lane) / 2))) & 32'hFFFF;
            bits = 16;
        end else begin
            return word;
        end
        if (!uns && v >= (32'd1 << (bits - 1))) v = v - (32'd1 << bits);
        return v;
    endfunction

    function automatic logic [3:0] modelBe(input logic [1:0] size, input logic [1:0] lane);
        logic [3:0] be;
        int         n;
        n  = 1 << int'(size);
        be = 4'h0;
        for (int i = 0; i < 4; i++)
            if (i >= int'(lane) && i < int'(lane) + n) be[i] = 1'b1;
        return be;
    endfunction

    function automatic logic [31:0] modelWdata(input logic [1:0] size, input logic [31:0] rt);
        logic [31:0] w;
        int          n;
        n = 1 << int'(size);
        w = 32'h0;
        for (int i = 0; i < 4; i++) w[8*i +: 8] = rt[8*(i % n) +: 8];
        return w;
    endfunction

    function automatic EX_MEM_Register makeOp(input logic rd_en, input logic wr_en, input logic [1:0] size,
                                              input logic uns, input logic [31:0] addr, input logic [31:0] rs,
                                              input logic [31:0] rt, input logic [4:0] rd, input logic sys);
        EX_MEM_Register op;
        op                   = '0;
        op.valid             = 1'b1;
        op.ctrl.mem_read     = rd_en;
        op.ctrl.mem_write    = wr_en;
        op.ctrl.mem_size     = MemSize'(size);
        op.ctrl.mem_unsigned = uns;
        op.ctrl.reg_write    = !wr_en && !sys;
        op.ctrl.is_syscall   = sys;
        op.alu_result        = addr;
        op.rs_data           = rs;
        op.rt_data           = rt;
        op.reg_write_addr    = rd;
        return op;
    endfunction

    task automatic runNonMem(input EX_MEM_Register op, input string tag);
        applyStimulus(op);
        checkOutput({tag, "_nostall"}, 32'(mem_stall_req), 32'd0);
        tick();
        applyStimulus('0);
        checkOutput({tag, "_valid"}, 32'(mem_wb_reg.valid), 32'd1);
        checkOutput({tag, "_data"}, mem_wb_reg.reg_write_data, op.alu_result);
        checkOutput({tag, "_rs"}, mem_wb_reg.rs_data, op.rs_data);
        checkOutput({tag, "_rt"}, mem_wb_reg.rt_data, op.rt_data);
        checkOutput({tag, "_rd"}, 32'(mem_wb_reg.reg_write_addr), 32'(op.reg_write_addr));
        checkOutput({tag, "_sys"}, 32'(mem_wb_reg.ctrl.is_syscall), 32'(op.ctrl.is_syscall));
    endtask

    task automatic runMem(input EX_MEM_Register op, input logic [31:0] word, input int waits,
                          input logic [31:0] exp_data, input string tag);
        int         stall_cnt;
        logic [1:0] size;
        size = op.ctrl.mem_size;
        applyStimulus(op);
        stall_cnt = mem_stall_req ? 1 : 0;
        tick();
        checkOutput({tag, "_req"}, 32'(dmem_req), 32'd1);
        checkOutput({tag, "_addr"}, dmem_addr, op.alu_result & 32'hFFFF_FFFC);
        checkOutput({tag, "_we"}, 32'(dmem_we), 32'(op.ctrl.mem_write));
        checkOutput({tag, "_be"}, 32'(dmem_be),
                    op.ctrl.mem_write ? 32'(modelBe(size, op.alu_result[1:0])) : 32'd0);
        if (op.ctrl.mem_write)
            checkOutput({tag, "_wdata"}, dmem_wdata, modelWdata(size, op.rt_data));
        for (int i = 0; i < waits; i++) begin
            if (mem_stall_req) stall_cnt++;
            tick();
            checkOutput({tag, "_req_held"}, 32'(dmem_req), 32'd1);
        end
        dmem_ready = 1'b1;
        dmem_rdata = word;
        #1;
        checkOutput({tag, "_stall_drop"}, 32'(mem_stall_req), 32'd0);
        tick();
        dmem_ready = 1'b0;
        applyStimulus('0);
        checkOutput({tag, "_stall_cycles"}, 32'(stall_cnt), 32'(waits + 1));
        checkOutput({tag, "_req_low"}, 32'(dmem_req), 32'd0);
        checkOutput({tag, "_wb_valid"}, 32'(mem_wb_reg.valid), 32'd1);
        checkOutput({tag, "_wb_regwr"}, 32'(mem_wb_reg.ctrl.reg_write), 32'(op.ctrl.reg_write));
        if (op.ctrl.mem_read) begin
            checkOutput({tag, "_wb_data"}, mem_wb_reg.reg_write_data, exp_data);
            checkOutput({tag, "_wb_rd"}, 32'(mem_wb_reg.reg_write_addr), 32'(op.reg_write_addr));
        end
    endtask

    task automatic runMisaligned(input EX_MEM_Register op, input string tag);
        applyStimulus(op);
        checkOutput({tag, "_nostall"}, 32'(mem_stall_req), 32'd0);
        tick();
        applyStimulus('0);
        checkOutput({tag, "_err"}, 32'(addr_error), 32'd1);
        checkOutput({tag, "_noreq"}, 32'(dmem_req), 32'd0);
        checkOutput({tag, "_wb_invalid"}, 32'(mem_wb_reg.valid), 32'd0);
        tick();
        checkOutput({tag, "_err_pulse"}, 32'(addr_error), 32'd0);
        checkOutput({tag, "_noreq2"}, 32'(dmem_req), 32'd0);
    endtask

    initial begin
        logic [1:0]  size;
        logic [1:0]  lane;
        logic        uns;
        logic        is_store;
        logic [31:0] base;
        logic [31:0] rs;
        logic [31:0] rt;
        logic [31:0] word;
        logic [4:0]  rd;
        int          kind;
        int          waits;

        rst        = 1'b1;
        flush      = 1'b0;
        stall      = 1'b0;
        dmem_ready = 1'b0;
        dmem_rdata = 32'h0;
        ex_mem_reg = '0;
        tick();
        tick();
        checkOutput("rst_req", 32'(dmem_req), 32'd0);
        checkOutput("rst_we", 32'(dmem_we), 32'd0);
        checkOutput("rst_addr", dmem_addr, 32'h0);
        checkOutput("rst_be", 32'(dmem_be), 32'd0);
        checkOutput("rst_wdata", dmem_wdata, 32'h0);
        checkOutput("rst_wb_zero", 32'(|mem_wb_reg), 32'd0);
        checkOutput("rst_err", 32'(addr_error), 32'd0);
        checkOutput("rst_stall", 32'(mem_stall_req), 32'd0);
        rst = 1'b0;

        runMem(makeOp(1, 0, 2'd2, 0, 32'h100, 0, 0, 5'd8, 0), 32'hDEADBEEF, 3, 32'hDEADBEEF, "lw");
        runMem(makeOp(1, 0, 2'd0, 0, 32'h203, 0, 0, 5'd9, 0), 32'h80FF7F01, 1, 32'hFFFFFF80, "lb");
        runMem(makeOp(1, 0, 2'd0, 1, 32'h203, 0, 0, 5'd10, 0), 32'h80FF7F01, 0, 32'h00000080, "lbu");
        runMem(makeOp(1, 0, 2'd1, 0, 32'h202, 0, 0, 5'd11, 0), 32'h80FF7F01, 2, 32'hFFFF80FF, "lh");
        runMem(makeOp(0, 1, 2'd0, 0, 32'h301, 0, 32'h12345678, 5'd0, 0), 32'h0, 1, 32'h0, "sb");
        runMisaligned(makeOp(1, 0, 2'd2, 0, 32'h102, 0, 0, 5'd12, 0), "lw_mis");

        // Flush arrives in the second ACCESS cycle; the bus must still complete.
        applyStimulus(makeOp(1, 0, 2'd2, 0, 32'h500, 0, 0, 5'd13, 0));
        tick();
        tick();
        flush = 1'b1;
        applyStimulus('0);
        tick();
        flush = 1'b0;
        checkOutput("flush_req_held", 32'(dmem_req), 32'd1);
        dmem_ready = 1'b1;
        dmem_rdata = 32'h11112222;
        tick();
        dmem_ready = 1'b0;
        #1;
        checkOutput("flush_req_low", 32'(dmem_req), 32'd0);
        checkOutput("flush_wb_invalid", 32'(mem_wb_reg.valid), 32'd0);
        checkOutput("flush_stall_low", 32'(mem_stall_req), 32'd0);

        // Syscall passes through, then a load completes under a 2-cycle stall.
        runNonMem(makeOp(0, 0, 2'd0, 0, 32'h0000000C, 32'd1, 32'd42, 5'd0, 1), "syscall");
        stall = 1'b1;
        applyStimulus(makeOp(1, 0, 2'd2, 0, 32'h400, 0, 0, 5'd14, 0));
        tick();
        checkOutput("stl_req", 32'(dmem_req), 32'd1);
        checkOutput("stl_wb_hold0", mem_wb_reg.reg_write_data, 32'h0000000C);
        dmem_ready = 1'b1;
        dmem_rdata = 32'hCAFEF00D;
        #1;
        tick();
        dmem_ready = 1'b0;
        applyStimulus('0);
        for (int i = 0; i < 2; i++) begin
            checkOutput("stl_done_stall", 32'(mem_stall_req), 32'd1);
            checkOutput("stl_req_low", 32'(dmem_req), 32'd0);
            checkOutput("stl_wb_hold", mem_wb_reg.reg_write_data, 32'h0000000C);
            checkOutput("stl_wb_sys", 32'(mem_wb_reg.ctrl.is_syscall), 32'd1);
            if (i == 0) tick();
        end
        stall = 1'b0;
        #1;
        tick();
        checkOutput("stl_result", mem_wb_reg.reg_write_data, 32'hCAFEF00D);
        checkOutput("stl_valid", 32'(mem_wb_reg.valid), 32'd1);
        checkOutput("stl_rd", 32'(mem_wb_reg.reg_write_addr), 32'd14);
        checkOutput("stl_idle", 32'(mem_stall_req), 32'd0);

        // Reset while a request is outstanding.
        applyStimulus(makeOp(1, 0, 2'd2, 0, 32'h600, 0, 0, 5'd15, 0));
        tick();
        checkOutput("rstmid_req", 32'(dmem_req), 32'd1);
        rst = 1'b1;
        applyStimulus('0);
        tick();
        rst = 1'b0;
        checkOutput("rstmid_req_low", 32'(dmem_req), 32'd0);
        checkOutput("rstmid_stall", 32'(mem_stall_req), 32'd0);
        dmem_ready = 1'b1;
        dmem_rdata = 32'h55555555;
        tick();
        dmem_ready = 1'b0;
        checkOutput("rstmid_noresult", 32'(mem_wb_reg.valid), 32'd0);

        for (int n = 0; n < 40; n++) begin
            kind  = int'($urandom_range(0, 3));
            size  = 2'($urandom_range(0, 2));
            uns   = 1'($urandom_range(0, 1));
            base  = $urandom & 32'hFFFF_FFFC;
            rs    = $urandom;
            rt    = $urandom;
            word  = $urandom;
            rd    = 5'($urandom_range(1, 31));
            waits = int'($urandom_range(0, 3));
            is_store = 1'($urandom_range(0, 1));
            if (kind == 3) begin
                if (size == 2'd0) size = 2'd2;
                lane = (size == 2'd1) ? {1'($urandom_range(0, 1)), 1'b1} : 2'($urandom_range(1, 3));
            end else begin
                lane = (size == 2'd0) ? 2'($urandom_range(0, 3)) :
                       (size == 2'd1) ? {1'($urandom_range(0, 1)), 1'b0} : 2'b00;
            end
            case (kind)
                0: runNonMem(makeOp(0, 0, 2'd0, 0, $urandom, rs, rt, rd, 0), "rnd_alu");
                1: runMem(makeOp(1, 0, size, uns, base | 32'(lane), rs, rt, rd, 0), word, waits,
                          modelLoad(size, uns, lane, word), "rnd_ld");
                2: runMem(makeOp(0, 1, size, 0, base | 32'(lane), rs, rt, 5'd0, 0), word, waits,
                          32'h0, "rnd_st");
                default: runMisaligned(makeOp(!is_store, is_store, size, uns, base | 32'(lane), rs, rt, rd, 0),
                                       "rnd_mis");
            endcase
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
